// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the arb4_mux_ctrl round-robin arbiter:
//   state_t  - two-state arbiter FSM encoding (IDLE / GRANT)
//   NREQ     - number of requesters
//   IDXW     - width of a requester index / mux select
//   LAST_RST - reset value of the round-robin pointer, chosen so that
//              source 0 is searched first after reset
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NREQ = 4;
    localparam int IDXW = 2;

    localparam logic [IDXW-1:0] LAST_RST = 2'd3;

endpackage : arb_pkg

// File: rtl/arb4_mux_ctrl_mux4_w.sv
// -----------------------------------------------------------------------------
// mux4_w
// W-bit 4:1 multiplexer with output enable. The output is forced to zero
// whenever en is low, so no source data leaks out while nothing is granted.
//
// Ports:
//   d0..d3  in  [W-1:0]  source data
//   s1, s0  in  1        select, {s1,s0} is the source index
//   en      in  1        output enable (driven from the arbiter's valid)
//   y       out [W-1:0]  selected data, or 0 when en is low
// -----------------------------------------------------------------------------
module mux4_w #(
    parameter int W = 8
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic         s1,
    input  logic         s0,
    input  logic         en,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            unique case ({s1, s0})
                2'd0:    y = d0;
                2'd1:    y = d1;
                2'd2:    y = d2;
                default: y = d3;
            endcase
        end
    end

endmodule : mux4_w

// File: rtl/arb4_mux_ctrl.sv
// -----------------------------------------------------------------------------
// arb4_mux_ctrl
// Four-requester round-robin arbiter that owns the selects of a W-bit 4:1
// mux. A grant is held until the owner drops its request; at least one IDLE
// cycle separates consecutive grants.
//
// Optional feature: define ARB_TIMEOUT_EN to add a hold counter that forcibly
// releases a grant after MAX_HOLD cycles (MAX_HOLD legal range 1..255).
// Without the macro, MAX_HOLD is ignored and grants are held indefinitely.
//
// Ports:
//   clk      in   1        rising-edge clock
//   rst      in   1        asynchronous active-high reset
//   req      in   4        per-source request
//   d0..d3   in   [W-1:0]  source data
//   gnt      out  4        registered one-hot grant, 0 when idle
//   s1, s0   out  1        registered mux select (index of granted source)
//   valid    out  1        registered, high while a grant is held
//   y        out  [W-1:0]  selected data, 0 when valid is low
// -----------------------------------------------------------------------------
module arb4_mux_ctrl
    import arb_pkg::*;
#(
    parameter int W        = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [W-1:0]    d0,
    input  logic [W-1:0]    d1,
    input  logic [W-1:0]    d2,
    input  logic [W-1:0]    d3,
    output logic [NREQ-1:0] gnt,
    output logic            s1,
    output logic            s0,
    output logic            valid,
    output logic [W-1:0]    y
);

    // Out-of-range MAX_HOLD is reported by name in the elaborated hierarchy.
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_illegal_max_hold
    end

    state_t            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [IDXW-1:0]   sel_q;
    logic [IDXW-1:0]   last_q;
    logic              valid_q;

    // Candidate index for each search position: last+1, last+2, ... (mod 4),
    // and the request bit belonging to that candidate.
    logic [IDXW-1:0]   cand_idx [NREQ];
    logic [NREQ-1:0]   rot_req;
    logic [IDXW-1:0]   win_d;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rotate
        assign cand_idx[gi] = last_q + IDXW'(gi + 1);
        assign rot_req[gi]  = req[cand_idx[gi]];
    end

    // First requesting candidate in rotated order wins.
    always_comb begin
        win_d = cand_idx[NREQ-1];
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                win_d = cand_idx[k];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q;
    logic       hold_expire;

    // Expires on the edge where the count would reach MAX_HOLD.
    assign hold_expire = (hold_q + 8'd1) == 8'(MAX_HOLD);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= LAST_RST;
            valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
`ifdef ARB_TIMEOUT_EN
                    hold_q <= '0;
`endif
                    if (|req) begin
                        state_q <= GRANT;
                        gnt_q   <= NREQ'(1) << win_d;
                        sel_q   <= win_d;
                        last_q  <= win_d;
                        valid_q <= 1'b1;
                    end else begin
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!req[sel_q]) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    // last_q already holds the owner, so a pre-empted source
                    // drops to lowest priority for the next search.
                    else if (hold_expire) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                        hold_q  <= '0;
                    end else begin
                        hold_q  <= hold_q + 8'd1;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign s1    = sel_q[1];
    assign s0    = sel_q[0];
    assign valid = valid_q;

    mux4_w #(.W(W)) u_mux (
        .d0 (d0),
        .d1 (d1),
        .d2 (d2),
        .d3 (d3),
        .s1 (sel_q[1]),
        .s0 (sel_q[0]),
        .en (valid_q),
        .y  (y)
    );

endmodule : arb4_mux_ctrl

// File: tb/tb_arb4_mux_ctrl.sv
// -----------------------------------------------------------------------------
// tb_arb4_mux_ctrl
// Scoreboard bench for arb4_mux_ctrl. A reference model tracks the current
// owner as an integer (-1 = nobody) and the round-robin pointer; on every
// clock edge it pushes the expected owner into a queue. A monitor on the
// falling edge pops that owner and checks gnt, selects, valid and y.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arb4_mux_ctrl;

    localparam int W  = 8;
    localparam int MH = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   gnt;
    logic         s1, s0, valid;
    logic [W-1:0] y;

    arb4_mux_ctrl #(.W(W), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .gnt   (gnt),
        .s1    (s1),
        .s0    (s0),
        .valid (valid),
        .y     (y)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];

    // Reference model state
    int m_owner = -1;
    int m_last  = 3;
    int m_hold  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int pick_winner(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] data_of(input int idx);
        case (idx)
            0:       return d0;
            1:       return d1;
            2:       return d2;
            3:       return d3;
            default: return '0;
        endcase
    endfunction

    // Reference model: one decision per rising edge from the sampled req.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_last  = 3;
            m_hold  = 0;
            exp_q.delete();
        end else begin
            if (m_owner < 0) begin
                m_owner = pick_winner(req, m_last);
                if (m_owner >= 0) m_last = m_owner;
                m_hold = 0;
            end else if (!req[m_owner]) begin
                m_owner = -1;
            end
`ifdef ARB_TIMEOUT_EN
            else begin
                m_hold++;
                if (m_hold == MH) begin
                    m_owner = -1;
                    m_hold  = 0;
                end
            end
`endif
            exp_q.push_back(m_owner);
        end
    end

    // Monitor
    always @(negedge clk) begin
        int e;
        if (rst) begin
            chk("rst_gnt",   {28'd0, gnt},   32'd0);
            chk("rst_valid", {31'd0, valid}, 32'd0);
            chk("rst_sel",   {30'd0, s1, s0}, 32'd0);
            chk("rst_y",     {24'd0, y},     32'd0);
        end else if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("gnt",   {28'd0, gnt},    (e >= 0) ? (32'd1 << e) : 32'd0);
            chk("valid", {31'd0, valid},  (e >= 0) ? 32'd1 : 32'd0);
            if (e >= 0) chk("sel", {30'd0, s1, s0}, 32'(e));
            chk("y",     {24'd0, y},      {24'd0, data_of(e)});
        end
    end

    // Drive req for the next edge and randomize source data.
    task automatic cyc(input logic [3:0] r);
        @(posedge clk);
        #1;
        req = r;
        d0  = W'($urandom);
        d1  = W'($urandom);
        d2  = W'($urandom);
        d3  = W'($urandom);
    endtask

    initial begin
        logic [3:0] r;
        rst = 1'b1;
        req = '0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Single requester 2 with known data
        cyc(4'b0000);
        cyc(4'b0100); d2 = 8'hA5;
        cyc(4'b0100); d2 = 8'hA5;
        cyc(4'b0100); d2 = 8'hA5;
        cyc(4'b0000);
        cyc(4'b0000);

        // All requesting; the owner drops one cycle after its grant
        for (int i = 0; i < 14; i++) begin
            cyc(4'b1111);
            req = 4'b1111 & ~gnt;
        end
        cyc(4'b0000);

        // Owner 1 holds while source 3 waits
        cyc(4'b0010);
        for (int i = 0; i < 6; i++) cyc(4'b1010);
        cyc(4'b1000);
        cyc(4'b1000);
        cyc(4'b1000);
        cyc(4'b0000);

        // Asynchronous reset mid-grant of source 3
        cyc(4'b1000);
        cyc(4'b1000);
        cyc(4'b1000);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_gnt",   {28'd0, gnt},   32'd0);
        chk("async_valid", {31'd0, valid}, 32'd0);
        chk("async_y",     {24'd0, y},     32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        req = 4'b1001;
        cyc(4'b1001);
        cyc(4'b1001);
        cyc(4'b0000);

        // Idle with toggling data
        for (int i = 0; i < 6; i++) cyc(4'b0000);

        // Constant two-source contention (exercises timeout when enabled)
        for (int i = 0; i < 40; i++) cyc(4'b0011);
        cyc(4'b0000);

        // Random requests: each bit flips with probability 1/4 per cycle
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            end
            cyc(r);
        end

        cyc(4'b0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_arb4_mux_ctrl
